// File: rtl/ex_stage.sv
// Execute stage: MEM/WB operand forwarding, ALU, branch resolution and the EX/MEM register.
// Also raises the load-use stall request and the one-cycle flush after a taken branch.
module ex_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RFAW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vld_EX,
   input  logic [XLEN-1:0] pc_EX,
   input  logic [XLEN-1:0] rda_EX,
   input  logic [XLEN-1:0] rdb_EX,
   input  logic [XLEN-1:0] imm_EX,
   input  logic [RFAW-1:0] wa_EX,
   input  logic [RFAW-1:0] ra1_EX,
   input  logic [RFAW-1:0] ra2_EX,
   input  logic            funct7_EX,
   input  logic [2:0]      funct3_EX,
   input  logic            ALUsrc_EX,
   input  logic [1:0]      ALUOP_EX,
   input  logic            regwrite_EX,
   input  logic            branch_EX,
   input  logic            memread_EX,
   input  logic            memwrite_EX,
   input  logic            memtoreg_EX,
   input  logic [RFAW-1:0] ra1_ID,
   input  logic [RFAW-1:0] ra2_ID,
   input  logic            wb_regwrite,
   input  logic [RFAW-1:0] wb_wa,
   input  logic [XLEN-1:0] wb_wd,
   output logic [XLEN-1:0] alu_MEM,
   output logic [XLEN-1:0] wd_MEM,
   output logic [RFAW-1:0] wa_MEM,
   output logic [2:0]      funct3_MEM,
   output logic            regwrite_MEM,
   output logic            memread_MEM,
   output logic            memwrite_MEM,
   output logic            memtoreg_MEM,
   output logic            stall_ID,
   output logic            flush,
   output logic [XLEN-1:0] br_target
);

   logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
   logic [4:0]      shamt;
   logic            sub_sel, cmp, taken, live;

   // Operand forwarding: the younger MEM result beats WB; x0 is never forwarded
   always_comb begin
      fwd_a = rda_EX;
      if (regwrite_MEM && (wa_MEM != '0) && (wa_MEM == ra1_EX))
         fwd_a = alu_MEM;
      else if (wb_regwrite && (wb_wa != '0) && (wb_wa == ra1_EX))
         fwd_a = wb_wd;
      fwd_b = rdb_EX;
      if (regwrite_MEM && (wa_MEM != '0) && (wa_MEM == ra2_EX))
         fwd_b = alu_MEM;
      else if (wb_regwrite && (wb_wa != '0) && (wb_wa == ra2_EX))
         fwd_b = wb_wd;
   end

   assign op_b  = ALUsrc_EX ? imm_EX : fwd_b;
   assign shamt = op_b[4:0];

   // I-type arithmetic ignores funct7 except for the srai/srli split
   always_comb begin
      alu_res = '0;
      sub_sel = (ALUOP_EX == 2'b10) && funct7_EX;
      case (ALUOP_EX)
         2'b00: alu_res = fwd_a + op_b;
         2'b01: alu_res = fwd_a - op_b;
         default: begin
            case (funct3_EX)
               3'b000: alu_res = sub_sel ? (fwd_a - op_b) : (fwd_a + op_b);
               3'b001: alu_res = fwd_a << shamt;
               3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
               3'b011: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
               3'b100: alu_res = fwd_a ^ op_b;
               3'b101: alu_res = funct7_EX ? XLEN'($signed(fwd_a) >>> shamt) : (fwd_a >> shamt);
               3'b110: alu_res = fwd_a | op_b;
               default: alu_res = fwd_a & op_b;
            endcase
         end
      endcase
   end

   // Branch condition on the forwarded register operands
   always_comb begin
      cmp = 1'b0;
      case (funct3_EX)
         3'b000: cmp = (fwd_a == fwd_b);
         3'b001: cmp = (fwd_a != fwd_b);
         3'b100: cmp = ($signed(fwd_a) < $signed(fwd_b));
         3'b101: cmp = ($signed(fwd_a) >= $signed(fwd_b));
         3'b110: cmp = (fwd_a < fwd_b);
         3'b111: cmp = (fwd_a >= fwd_b);
         default: cmp = 1'b0;
      endcase
   end

   assign live     = vld_EX && !flush;
   assign taken    = live && branch_EX && cmp;
   assign stall_ID = live && memread_EX && (wa_EX != '0) &&
                     ((wa_EX == ra1_ID) || (wa_EX == ra2_ID));

   // EX/MEM register; bubbles, wrong-path slots and branches carry no side effects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_MEM      <= '0;
         wd_MEM       <= '0;
         wa_MEM       <= '0;
         funct3_MEM   <= '0;
         regwrite_MEM <= 1'b0;
         memread_MEM  <= 1'b0;
         memwrite_MEM <= 1'b0;
         memtoreg_MEM <= 1'b0;
         flush        <= 1'b0;
         br_target    <= '0;
      end else begin
         alu_MEM      <= alu_res;
         wd_MEM       <= fwd_b;
         wa_MEM       <= wa_EX;
         funct3_MEM   <= funct3_EX;
         regwrite_MEM <= live && regwrite_EX && !branch_EX;
         memread_MEM  <= live && memread_EX;
         memwrite_MEM <= live && memwrite_EX && !branch_EX;
         memtoreg_MEM <= live && memtoreg_EX;
         flush        <= taken;
         if (taken)
            br_target <= pc_EX + imm_EX;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed pipeline scenarios plus random traffic against a behavioural model.
module tb_ex_stage;
   localparam int unsigned XLEN = 32;
   localparam int unsigned RFAW = 5;

   logic clk = 1'b0, rst = 1'b1;
   logic vld_EX, funct7_EX, ALUsrc_EX, regwrite_EX, branch_EX, memread_EX, memwrite_EX, memtoreg_EX;
   logic [XLEN-1:0] pc_EX, rda_EX, rdb_EX, imm_EX, wb_wd;
   logic [RFAW-1:0] wa_EX, ra1_EX, ra2_EX, ra1_ID, ra2_ID, wb_wa;
   logic [2:0] funct3_EX;
   logic [1:0] ALUOP_EX;
   logic wb_regwrite;
   logic [XLEN-1:0] alu_MEM, wd_MEM, br_target;
   logic [RFAW-1:0] wa_MEM;
   logic [2:0] funct3_MEM;
   logic regwrite_MEM, memread_MEM, memwrite_MEM, memtoreg_MEM, stall_ID, flush;

   ex_stage #(.XLEN(XLEN), .RFAW(RFAW)) dut (
      .clk(clk), .rst(rst), .vld_EX(vld_EX), .pc_EX(pc_EX), .rda_EX(rda_EX), .rdb_EX(rdb_EX),
      .imm_EX(imm_EX), .wa_EX(wa_EX), .ra1_EX(ra1_EX), .ra2_EX(ra2_EX), .funct7_EX(funct7_EX),
      .funct3_EX(funct3_EX), .ALUsrc_EX(ALUsrc_EX), .ALUOP_EX(ALUOP_EX), .regwrite_EX(regwrite_EX),
      .branch_EX(branch_EX), .memread_EX(memread_EX), .memwrite_EX(memwrite_EX),
      .memtoreg_EX(memtoreg_EX), .ra1_ID(ra1_ID), .ra2_ID(ra2_ID), .wb_regwrite(wb_regwrite),
      .wb_wa(wb_wa), .wb_wd(wb_wd), .alu_MEM(alu_MEM), .wd_MEM(wd_MEM), .wa_MEM(wa_MEM),
      .funct3_MEM(funct3_MEM), .regwrite_MEM(regwrite_MEM), .memread_MEM(memread_MEM),
      .memwrite_MEM(memwrite_MEM), .memtoreg_MEM(memtoreg_MEM), .stall_ID(stall_ID),
      .flush(flush), .br_target(br_target));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;

   // Model of the EX/MEM register contents
   logic [31:0] m_alu, m_wd, m_tgt;
   logic [4:0]  m_wa;
   logic [2:0]  m_f3;
   bit m_rw, m_mr, m_mw, m_mt, m_flush;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] regval);
      if (m_rw && m_wa != 0 && m_wa == ra) return m_alu;
      if (wb_regwrite && wb_wa != 0 && wb_wa == ra) return wb_wd;
      return regval;
   endfunction

   function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [2:0] f3,
                                             input bit f7, input logic [31:0] a, input logic [31:0] b);
      int sh = int'(b[4:0]);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'(a);
      longint ub = longint'(b);
      if (op == 2'b00) return 32'(ua + ub);
      if (op == 2'b01) return 32'(ua - ub);
      case (f3)
         3'd0: return (op == 2'b10 && f7) ? 32'(ua - ub) : 32'(ua + ub);
         3'd1: return 32'(ua * (longint'(1) << sh));
         3'd2: return (sa < sb) ? 32'd1 : 32'd0;
         3'd3: return (ua < ub) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return f7 ? 32'(sa >>> sh) : 32'(ua >> sh);
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic bit br_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return longint'(a) < longint'(b);
         3'd7: return longint'(a) >= longint'(b);
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_idle();
      vld_EX = 0; pc_EX = 0; rda_EX = 0; rdb_EX = 0; imm_EX = 0; wa_EX = 0; ra1_EX = 0; ra2_EX = 0;
      funct7_EX = 0; funct3_EX = 0; ALUsrc_EX = 0; ALUOP_EX = 0; regwrite_EX = 0; branch_EX = 0;
      memread_EX = 0; memwrite_EX = 0; memtoreg_EX = 0; ra1_ID = 0; ra2_ID = 0;
      wb_regwrite = 0; wb_wa = 0; wb_wd = 0;
   endtask

   task automatic model_zero();
      m_alu = 0; m_wd = 0; m_tgt = 0; m_wa = 0; m_f3 = 0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_mt = 0; m_flush = 0;
   endtask

   // Inputs are already driven (after a falling edge): check stall, clock once, check registers
   task automatic apply();
      logic [31:0] fa, fb, n_alu, n_tgt;
      bit live, taken, exp_stall;
      #1;
      live = vld_EX && !m_flush;
      exp_stall = live && memread_EX && wa_EX != 0 && (wa_EX == ra1_ID || wa_EX == ra2_ID);
      check("stall_ID", 32'(stall_ID), 32'(exp_stall));
      fa = fwd(ra1_EX, rda_EX);
      fb = fwd(ra2_EX, rdb_EX);
      n_alu = alu_model(ALUOP_EX, funct3_EX, funct7_EX, fa, ALUsrc_EX ? imm_EX : fb);
      taken = live && branch_EX && br_model(funct3_EX, fa, fb);
      n_tgt = taken ? pc_EX + imm_EX : m_tgt;
      @(posedge clk);
      m_alu = n_alu; m_wd = fb; m_wa = wa_EX; m_f3 = funct3_EX; m_tgt = n_tgt;
      m_rw = live && regwrite_EX && !branch_EX;
      m_mr = live && memread_EX;
      m_mw = live && memwrite_EX && !branch_EX;
      m_mt = live && memtoreg_EX;
      m_flush = taken;
      #1;
      check("alu_MEM", alu_MEM, m_alu);
      check("wd_MEM", wd_MEM, m_wd);
      check("wa_MEM", 32'(wa_MEM), 32'(m_wa));
      check("funct3_MEM", 32'(funct3_MEM), 32'(m_f3));
      check("regwrite_MEM", 32'(regwrite_MEM), 32'(m_rw));
      check("memread_MEM", 32'(memread_MEM), 32'(m_mr));
      check("memwrite_MEM", 32'(memwrite_MEM), 32'(m_mw));
      check("memtoreg_MEM", 32'(memtoreg_MEM), 32'(m_mt));
      check("flush", 32'(flush), 32'(m_flush));
      if (m_flush) check("br_target", br_target, m_tgt);
   endtask

   task automatic alu_op(input logic [1:0] op, input logic [2:0] f3, input bit f7, input bit src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      @(negedge clk);
      set_idle();
      vld_EX = 1; regwrite_EX = 1; ALUOP_EX = op; funct3_EX = f3; funct7_EX = f7; ALUsrc_EX = src;
      rda_EX = a; rdb_EX = b; imm_EX = imm; ra1_EX = rs1; ra2_EX = rs2; wa_EX = rd;
   endtask

   task automatic branch_op(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      set_idle();
      vld_EX = 1; branch_EX = 1; ALUOP_EX = 2'b01; funct3_EX = f3; pc_EX = pc; imm_EX = imm;
      rda_EX = a; rdb_EX = b;
   endtask

   task automatic mid_reset(input bit pre_rw, input bit pre_flush);
      check("pre_reset_regwrite", 32'(regwrite_MEM), 32'(pre_rw));
      check("pre_reset_flush", 32'(flush), 32'(pre_flush));
      #2 rst = 1;
      #1;
      check("rst_alu", alu_MEM, 0);          check("rst_wd", wd_MEM, 0);
      check("rst_wa", 32'(wa_MEM), 0);       check("rst_f3", 32'(funct3_MEM), 0);
      check("rst_rw", 32'(regwrite_MEM), 0); check("rst_mr", 32'(memread_MEM), 0);
      check("rst_mw", 32'(memwrite_MEM), 0); check("rst_mt", 32'(memtoreg_MEM), 0);
      check("rst_flush", 32'(flush), 0);     check("rst_tgt", br_target, 0);
      model_zero();
      @(negedge clk); set_idle();
      @(negedge clk); rst = 0;
      for (int i = 0; i < 2; i++) begin
         apply();
         check("post_rst_rw", 32'(regwrite_MEM), 0);
         check("post_rst_flush", 32'(flush), 0);
         @(negedge clk);
      end
   endtask

   initial begin
      set_idle();
      model_zero();
      #12;
      check("reset_alu", alu_MEM, 0);
      check("reset_flush", 32'(flush), 0);
      @(negedge clk); rst = 0;
      set_idle(); apply();

      // add x3,x1,x2 then sub x4,x3,x1 with stale rda (MEM forward), then again with WB x3=99
      alu_op(2'b10, 3'd0, 0, 0, 5, 7, 0, 5'd1, 5'd2, 5'd3); apply();
      check("add_x3", alu_MEM, 32'd12);
      alu_op(2'b10, 3'd0, 1, 0, 0, 5, 0, 5'd3, 5'd1, 5'd4); apply();
      check("sub_fwd_mem", alu_MEM, 32'd7);
      alu_op(2'b10, 3'd0, 0, 0, 5, 7, 0, 5'd1, 5'd2, 5'd3); apply();
      alu_op(2'b10, 3'd0, 1, 0, 0, 5, 0, 5'd3, 5'd1, 5'd4);
      wb_regwrite = 1; wb_wa = 5'd3; wb_wd = 32'd99; apply();
      check("sub_mem_over_wb", alu_MEM, 32'd7);
      mid_reset(1, 0);

      // load-use stall
      @(negedge clk); set_idle();
      vld_EX = 1; memread_EX = 1; wa_EX = 5; ra2_ID = 5; #1;
      check("stall_hit", 32'(stall_ID), 1);
      ra1_ID = 6; ra2_ID = 6; #1;
      check("stall_miss", 32'(stall_ID), 0);
      wa_EX = 0; ra1_ID = 0; #1;
      check("stall_x0", 32'(stall_ID), 0);
      apply();

      // beq taken, then wrong-path slot squashed and its stall suppressed
      branch_op(3'd0, 32'h100, 32'h20, 9, 9); apply();
      check("beq_flush", 32'(flush), 1);
      check("beq_target", br_target, 32'h120);
      @(negedge clk); set_idle();
      vld_EX = 1; regwrite_EX = 1; memread_EX = 1; wa_EX = 7; ra1_ID = 7; #1;
      check("stall_under_flush", 32'(stall_ID), 0);
      apply();
      check("squash_rw", 32'(regwrite_MEM), 0);
      check("flush_one_cycle", 32'(flush), 0);

      // bltu vs blt on 0xFFFFFFFF, 1
      branch_op(3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 1); apply();
      check("bltu_not_taken", 32'(flush), 0);
      branch_op(3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 1); apply();
      check("blt_taken", 32'(flush), 1);
      check("blt_target", br_target, 32'h240);
      mid_reset(0, 1);

      // shifts and set-less-than
      alu_op(2'b11, 3'd5, 1, 1, 32'h8000_0000, 0, 4, 0, 0, 5'd8); apply();
      check("srai", alu_MEM, 32'hF800_0000);
      alu_op(2'b11, 3'd5, 0, 1, 32'h8000_0000, 0, 4, 0, 0, 5'd8); apply();
      check("srli", alu_MEM, 32'h0800_0000);
      alu_op(2'b10, 3'd2, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 5'd9); apply();
      check("slt", alu_MEM, 32'd1);
      alu_op(2'b10, 3'd3, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 5'd9); apply();
      check("sltu", alu_MEM, 32'd0);
      alu_op(2'b11, 3'd0, 1, 1, 10, 0, 3, 0, 0, 5'd9); apply();
      check("addi_ignores_f7", alu_MEM, 32'd13);

      // random traffic with a small register set so hazards occur often
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         vld_EX = ($urandom_range(0, 3) != 0);
         pc_EX = $urandom & 32'hFFFF_FFFC;
         rda_EX = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
         rdb_EX = ($urandom_range(0, 3) == 0) ? rda_EX : $urandom;
         imm_EX = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63));
         wa_EX = 5'($urandom_range(0, 3));  ra1_EX = 5'($urandom_range(0, 3));
         ra2_EX = 5'($urandom_range(0, 3)); ra1_ID = 5'($urandom_range(0, 3));
         ra2_ID = 5'($urandom_range(0, 3)); wb_wa = 5'($urandom_range(0, 3));
         funct7_EX = 1'($urandom); funct3_EX = 3'($urandom); ALUsrc_EX = 1'($urandom);
         ALUOP_EX = 2'($urandom); regwrite_EX = 1'($urandom); branch_EX = ($urandom_range(0, 3) == 0);
         memread_EX = 1'($urandom); memwrite_EX = 1'($urandom); memtoreg_EX = 1'($urandom);
         wb_regwrite = 1'($urandom); wb_wd = $urandom;
         apply();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
